// File: rtl/erasure_capture_ctrl_if.sv
// Handshake bundle between the erasure-capture sequencer (master) and the
// erasure-position datapath (slave).
interface erasure_capture_ctrl_if #(
    parameter int AW = 5
);
    logic          init_erase_reg;
    logic          new_data;
    logic          erase_flag;
    logic          send_erasure_positions;
    logic [AW-1:0] erasure_addr;
    logic          erasure_ready;

    modport master (
        output init_erase_reg,
        output new_data,
        output erase_flag,
        output send_erasure_positions,
        output erasure_addr,
        input  erasure_ready
    );

    modport slave (
        input  init_erase_reg,
        input  new_data,
        input  erase_flag,
        input  send_erasure_positions,
        input  erasure_addr,
        output erasure_ready
    );
endinterface

// File: rtl/erasure_capture_ctrl.sv
// Per-codeword sequencer for the RS decoder erasure-capture datapath: seeds the
// store, streams symbols, counts erasures and reads captured positions back.
//
//  state     | meaning
//  ----------+------------------------------------------------------
//  IDLE      | waiting for start
//  INIT      | init_erase_reg pulse; symbol/erasure bookkeeping cleared
//  COLLECT   | forwarding symbols as new_data, counting erasures
//  READ_REQ  | send_erasure_positions pulse for erasure_addr
//  READ_WAIT | waiting for erasure_ready on the current address
//  DONE      | done pulse, back to IDLE
module erasure_capture_ctrl #(
    parameter int N_SYM     = 255,
    parameter int MAX_ERASE = 32,
    parameter int AW        = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sym_valid,
    input  logic                   erase_in,
    erasure_capture_ctrl_if.master dp,
    output logic [5:0]             erase_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);
    localparam int          SW      = $clog2(N_SYM);
    localparam logic [5:0]  MAX_CNT = 6'(MAX_ERASE);
    localparam logic [SW-1:0] SYM_TC = SW'(N_SYM - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COLLECT,
        READ_REQ,
        READ_WAIT,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] sym_left;
    logic [5:0]    cnt_upd;
    logic          last_sym;
    logic          last_read;

    // symbols remaining is a down-counter; terminal count marks the last symbol
    assign last_sym  = (sym_left == '0);
    assign last_read = (6'(dp.erasure_addr) == (erase_count - 6'd1));

    always_comb begin
        cnt_upd = erase_count;
        if (state == COLLECT && sym_valid && erase_in && erase_count < MAX_CNT)
            cnt_upd = erase_count + 6'd1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = INIT;
            INIT:      state_nx = COLLECT;
            COLLECT:   if (sym_valid && last_sym)
                           state_nx = (cnt_upd != 6'd0) ? READ_REQ : DONE;
            READ_REQ:  state_nx = READ_WAIT;
            READ_WAIT: if (dp.erasure_ready)
                           state_nx = last_read ? DONE : READ_REQ;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // state register; Moore strobes are registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state                     <= IDLE;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            dp.init_erase_reg         <= 1'b0;
            dp.send_erasure_positions <= 1'b0;
        end else begin
            state                     <= state_nx;
            busy                      <= (state_nx != IDLE);
            done                      <= (state_nx == DONE);
            dp.init_erase_reg         <= (state_nx == INIT);
            dp.send_erasure_positions <= (state_nx == READ_REQ);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sym_left        <= '0;
            erase_count     <= '0;
            overflow        <= 1'b0;
            dp.new_data     <= 1'b0;
            dp.erase_flag   <= 1'b0;
            dp.erasure_addr <= '0;
        end else begin
            dp.new_data   <= 1'b0;
            dp.erase_flag <= 1'b0;
            if (abort) begin
                dp.erasure_addr <= '0;
            end else begin
                case (state)
                    INIT: begin
                        sym_left        <= SYM_TC;
                        erase_count     <= '0;
                        overflow        <= 1'b0;
                        dp.erasure_addr <= '0;
                    end
                    COLLECT: if (sym_valid) begin
                        dp.new_data   <= 1'b1;
                        dp.erase_flag <= erase_in;
                        erase_count   <= cnt_upd;
                        if (!last_sym) sym_left <= sym_left - 1'b1;
                        if (erase_in && erase_count >= MAX_CNT) overflow <= 1'b1;
                    end
                    READ_WAIT: if (dp.erasure_ready && !last_read)
                        dp.erasure_addr <= dp.erasure_addr + 1'b1;
                    DONE: dp.erasure_addr <= '0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_erasure_capture_ctrl.sv
// Randomized bench for erasure_capture_ctrl against a codeword-level model:
// expected counts, overflow and readback addresses come from the erasure list.
module tb_erasure_capture_ctrl;
    localparam int AW    = 5;
    localparam int N_SYM = 255;
    localparam int MAXE  = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sym_valid = 1'b0;
    logic       erase_in = 1'b0;
    logic [5:0] erase_count;
    logic       overflow, busy, done;

    erasure_capture_ctrl_if #(.AW(AW)) dp_if ();

    erasure_capture_ctrl #(.N_SYM(N_SYM), .MAX_ERASE(MAXE), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sym_valid   (sym_valid),
        .erase_in    (erase_in),
        .dp          (dp_if),
        .erase_count (erase_count),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int mon_nd, mon_ef, mon_misalign, mon_send, mon_done, mon_init;

    always @(negedge clock) begin
        if (dp_if.new_data) mon_nd++;
        if (dp_if.erase_flag) mon_ef++;
        if (dp_if.erase_flag && !dp_if.new_data) mon_misalign++;
        if (dp_if.send_erasure_positions) mon_send++;
        if (done) mon_done++;
        if (dp_if.init_erase_reg) mon_init++;
    end

    task automatic mon_clear();
        mon_nd = 0; mon_ef = 0; mon_misalign = 0;
        mon_send = 0; mon_done = 0; mon_init = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [N_SYM-1:0] rand_flags(input int n);
        logic [N_SYM-1:0] f = '0;
        while ($countones(f) < n) f[$urandom_range(N_SYM-1, 0)] = 1'b1;
        return f;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_init"}, dp_if.init_erase_reg, 0);
        chk({tag, "_new_data"}, dp_if.new_data, 0);
        chk({tag, "_erase_flag"}, dp_if.erase_flag, 0);
        chk({tag, "_send"}, dp_if.send_erasure_positions, 0);
        chk({tag, "_addr"}, dp_if.erasure_addr, 0);
        chk({tag, "_count"}, erase_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // One full codeword: model expectations derive only from the erasure list.
    task automatic run_codeword(input logic [N_SYM-1:0] flags, input int gap_max,
                                input bit noisy, input int hold_at, input int abort_at);
        int nerase  = $countones(flags);
        int exp_cnt = (nerase > MAXE) ? MAXE : nerase;
        bit exp_ovf = (nerase > MAXE);
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_pulse", dp_if.init_erase_reg, 1);
        chk("busy_in_init", busy, 1);
        tick();
        chk("init_single_cycle", dp_if.init_erase_reg, 0);
        chk("init_clears_count", erase_count, 0);
        chk("init_clears_overflow", overflow, 0);
        for (int i = 0; i < N_SYM; i++) begin
            int g = $urandom_range(gap_max, 0);
            sym_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                erase_in = 1'($urandom);
                tick();
            end
            sym_valid = 1'b1;
            erase_in  = flags[i];
            tick();
        end
        sym_valid = noisy;
        erase_in  = noisy;
        if (exp_cnt == 0) begin
            chk("done_after_last_symbol", done, 1);
            chk("no_send_without_erasures", dp_if.send_erasure_positions, 0);
        end else begin
            chk("first_send_latency", dp_if.send_erasure_positions, 1);
            for (int a = 0; a < exp_cnt; a++) begin
                int d;
                int bad = 0;
                chk("send_seen", dp_if.send_erasure_positions, 1);
                chk("read_addr", dp_if.erasure_addr, a);
                tick();
                chk("send_one_cycle", dp_if.send_erasure_positions, 0);
                if (a == abort_at) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    chk("start_ignored_busy", dp_if.init_erase_reg, 0);
                    chk("start_ignored_addr", dp_if.erasure_addr, a);
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    sym_valid = 1'b0;
                    erase_in = 1'b0;
                    chk("abort_idle", busy, 0);
                    chk("abort_send_low", dp_if.send_erasure_positions, 0);
                    chk("abort_no_done", done, 0);
                    chk("abort_count_held", erase_count, exp_cnt);
                    tick();
                    chk("abort_no_done_later", mon_done, 0);
                    return;
                end
                d = (a == hold_at) ? 50 : $urandom_range(3, 0);
                for (int k = 0; k < d; k++) begin
                    if (dp_if.send_erasure_positions || dp_if.erasure_addr != AW'(a)
                        || !busy || done) bad++;
                    tick();
                end
                chk("wait_stable", bad, 0);
                dp_if.erasure_ready = 1'b1;
                tick();
                dp_if.erasure_ready = 1'b0;
            end
            chk("done_after_last_ready", done, 1);
        end
        tick();
        sym_valid = 1'b0;
        erase_in  = 1'b0;
        chk("done_single_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("addr_back_to_zero", dp_if.erasure_addr, 0);
        chk("erase_count", erase_count, exp_cnt);
        chk("overflow", overflow, exp_ovf);
        chk("new_data_pulses", mon_nd, N_SYM);
        chk("erase_flag_pulses", mon_ef, nerase);
        chk("erase_flag_aligned", mon_misalign, 0);
        chk("read_requests", mon_send, exp_cnt);
        chk("done_pulses", mon_done, 1);
        chk("init_pulses", mon_init, 1);
    endtask

    initial begin
        dp_if.erasure_ready = 1'b0;
        mon_clear();
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // reset in the middle of collecting a codeword
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            sym_valid = 1'b1;
            erase_in  = (i < 5);
            tick();
        end
        chk("pre_reset_count", erase_count, 5);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        tick();
        sym_valid = 1'b0;
        erase_in  = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_reset_idle", busy, 0);

        begin
            logic [N_SYM-1:0] f = '0;
            f[3] = 1'b1; f[100] = 1'b1; f[254] = 1'b1;
            run_codeword(f, 0, 1'b0, -1, -1);
        end
        run_codeword('0, 3, 1'b1, -1, -1);
        run_codeword(rand_flags(40), 1, 1'b0, -1, -1);
        run_codeword(rand_flags(2), 0, 1'b0, -1, -1);
        run_codeword(rand_flags(32), 0, 1'b0, -1, -1);
        run_codeword(rand_flags(33), 0, 1'b1, -1, -1);
        run_codeword(rand_flags(3), 1, 1'b0, -1, 1);
        run_codeword(rand_flags(5), 0, 1'b0, 2, -1);
        for (int r = 0; r < 4; r++) begin
            logic [N_SYM-1:0] f = '0;
            int p = $urandom_range(20, 0);
            for (int i = 0; i < N_SYM; i++) f[i] = ($urandom_range(99, 0) < p);
            run_codeword(f, $urandom_range(2, 0), 1'($urandom), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
